nv_ram_fifo_rd_ctrl_20x32: RTL and testbench

NV_RAM_FIFO_RD_CTRL_20X32 -- requirements
Module: nv_ram_fifo_rd_ctrl_20x32

---
 rtl/nv_ram_fifo_pkg.sv | 16 +
 rtl/nv_ram_fifo_skid3.sv | 50 +++++
 rtl/nv_ram_fifo_rd_ctrl_20x32.sv | 132 +++++++++++++
 tb/tb_nv_ram_fifo_rd_ctrl_20x32.sv | 235 +++++++++++++++++++++++
 4 files changed

// File: rtl/nv_ram_fifo_pkg.sv
`default_nettype none
// ============================================================================
// Module  : nv_ram_fifo_pkg
// Brief   : Shared defaults and types for the RAM-backed FIFO read controller.
// Revision: 1.0
// ============================================================================
package nv_ram_fifo_pkg;
    localparam int c_def_depth    = 20;
    localparam int c_def_width    = 32;
    localparam int c_def_aw       = 5;
    // Items allowed between read issue and the consumer (s1 + s2 + skid).
    localparam int c_credit_limit = 3;

    typedef logic [1:0] skid_cnt_t;
endpackage
`default_nettype wire

// File: rtl/nv_ram_fifo_skid3.sv
`default_nettype none
// ============================================================================
// Module  : nv_ram_fifo_skid3
// Brief   : Three-entry skid FIFO catching RAM output data the consumer stalls.
// Revision: 1.0
// ============================================================================
module nv_ram_fifo_skid3
    import nv_ram_fifo_pkg::*;
#(
    parameter int WIDTH = c_def_width
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_push,
    input  logic [WIDTH-1:0] i_push_data,
    input  logic             i_pop,
    output logic [1:0]       o_cnt,
    output logic [WIDTH-1:0] o_head
);
    logic [WIDTH-1:0] r_mem [3];
    logic [1:0]       r_wr_ptr;
    logic [1:0]       r_rd_ptr;
    skid_cnt_t        r_cnt;

    function automatic logic [1:0] ptr_next(input logic [1:0] p);
        return (p == 2'd2) ? 2'd0 : p + 2'd1;
    endfunction

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr <= 2'd0;
            r_rd_ptr <= 2'd0;
            r_cnt    <= 2'd0;
        end else begin
            if (i_push) r_wr_ptr <= ptr_next(r_wr_ptr);
            if (i_pop)  r_rd_ptr <= ptr_next(r_rd_ptr);
            if (i_push && !i_pop)      r_cnt <= r_cnt + 2'd1;
            else if (!i_push && i_pop) r_cnt <= r_cnt - 2'd1;
        end
    end

    // Storage needs no reset: the count alone defines which entries are live.
    always_ff @(posedge clk) begin
        if (i_push) r_mem[r_wr_ptr] <= i_push_data;
    end

    assign o_cnt  = r_cnt;
    assign o_head = r_mem[r_rd_ptr];
endmodule
`default_nettype wire

// File: rtl/nv_ram_fifo_rd_ctrl_20x32.sv
`default_nettype none
// ============================================================================
// Module  : nv_ram_fifo_rd_ctrl_20x32
// Brief   : Valid/ready FIFO controller around an external 2-stage-read RAM.
//           Optional empty-FIFO RAM bypass: NV_RAM_FIFO_RD_CTRL_BYPASS_EN.
// Revision: 1.0
// ============================================================================
module nv_ram_fifo_rd_ctrl_20x32
    import nv_ram_fifo_pkg::*;
#(
    parameter int DEPTH = c_def_depth,
    parameter int WIDTH = c_def_width,
    parameter int AW    = c_def_aw
) (
    input  logic             nvdla_core_clk,
    input  logic             nvdla_core_rstn,
    input  logic             wr_pvld,
    output logic             wr_prdy,
    input  logic [WIDTH-1:0] wr_pd,
    output logic             rd_pvld,
    input  logic             rd_prdy,
    output logic [WIDTH-1:0] rd_pd,
    output logic             ram_we,
    output logic [AW-1:0]    ram_wa,
    output logic [WIDTH-1:0] ram_di,
    output logic             ram_re,
    output logic [AW-1:0]    ram_ra,
    output logic             ram_ore,
    input  logic [WIDTH-1:0] ram_dout,
    output logic             ram_byp_sel,
    output logic [WIDTH-1:0] ram_dbyp,
    output logic [31:0]      ram_pwrbus_pd
);
    localparam int            CW         = $clog2(DEPTH + 1);
    localparam logic [CW-1:0] c_cnt_full = CW'(DEPTH);
    localparam logic [AW-1:0] c_ptr_last = AW'(DEPTH - 1);
    localparam logic [2:0]    c_credit   = 3'(c_credit_limit);

    logic [AW-1:0]    r_wr_ptr;
    logic [AW-1:0]    r_rd_ptr;
    logic [CW-1:0]    r_cnt;
    logic             r_s1;
    logic             r_s2;
    logic [1:0]       w_skid_cnt;
    logic [WIDTH-1:0] w_skid_head;
    logic             w_skid_empty;
    logic [2:0]       w_inflight;
    logic             w_wr_fire;
    logic             w_byp_fire;
    logic             w_ram_push;
    logic             w_issue;
    logic             w_rd_fire;
    logic             w_skid_push;
    logic             w_skid_pop;

    assign w_skid_empty = (w_skid_cnt == 2'd0);
    assign w_inflight   = {2'b00, r_s1} + {2'b00, r_s2} + {1'b0, w_skid_cnt};

    assign wr_prdy    = (r_cnt < c_cnt_full);
    assign w_wr_fire  = wr_pvld & wr_prdy;
    assign w_ram_push = w_wr_fire & ~w_byp_fire;
    // The credit guarantees the skid FIFO can absorb everything already issued.
    assign w_issue    = (r_cnt != '0) && (w_inflight < c_credit);

    assign ram_we        = w_ram_push;
    assign ram_wa        = r_wr_ptr;
    assign ram_di        = wr_pd;
    assign ram_re        = w_issue;
    assign ram_ra        = r_rd_ptr;
    assign ram_ore       = r_s1;
    assign ram_pwrbus_pd = 32'd0;

    assign rd_pvld     = r_s2 | ~w_skid_empty;
    assign rd_pd       = w_skid_empty ? ram_dout : w_skid_head;
    assign w_rd_fire   = rd_pvld & rd_prdy;
    assign w_skid_pop  = w_rd_fire & ~w_skid_empty;
    assign w_skid_push = r_s2 & (~w_skid_empty | ~rd_prdy);

`ifdef NV_RAM_FIFO_RD_CTRL_BYPASS_EN
    logic             r_byp_sel;
    logic [WIDTH-1:0] r_byp_data;

    assign w_byp_fire = w_wr_fire && (r_cnt == '0) && !r_s1 && !r_s2 && w_skid_empty;

    always_ff @(posedge nvdla_core_clk or negedge nvdla_core_rstn) begin
        if (!nvdla_core_rstn) begin
            r_byp_sel  <= 1'b0;
            r_byp_data <= '0;
        end else begin
            r_byp_sel <= w_byp_fire;
            if (w_byp_fire) r_byp_data <= wr_pd;
        end
    end

    assign ram_byp_sel = r_s1 & r_byp_sel;
    assign ram_dbyp    = r_byp_data;
`else
    assign w_byp_fire  = 1'b0;
    assign ram_byp_sel = 1'b0;
    assign ram_dbyp    = '0;
`endif

    always_ff @(posedge nvdla_core_clk or negedge nvdla_core_rstn) begin
        if (!nvdla_core_rstn) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_cnt    <= '0;
            r_s1     <= 1'b0;
            r_s2     <= 1'b0;
        end else begin
            if (w_ram_push) r_wr_ptr <= (r_wr_ptr == c_ptr_last) ? '0 : r_wr_ptr + AW'(1);
            if (w_issue)    r_rd_ptr <= (r_rd_ptr == c_ptr_last) ? '0 : r_rd_ptr + AW'(1);
            if (w_ram_push && !w_issue)      r_cnt <= r_cnt + CW'(1);
            else if (!w_ram_push && w_issue) r_cnt <= r_cnt - CW'(1);
            r_s1 <= w_issue | w_byp_fire;
            r_s2 <= r_s1;
        end
    end

    nv_ram_fifo_skid3 #(
        .WIDTH (WIDTH)
    ) u_skid (
        .clk         (nvdla_core_clk),
        .rst_n       (nvdla_core_rstn),
        .i_push      (w_skid_push),
        .i_push_data (ram_dout),
        .i_pop       (w_skid_pop),
        .o_cnt       (w_skid_cnt),
        .o_head      (w_skid_head)
    );
endmodule
`default_nettype wire

// File: tb/tb_nv_ram_fifo_rd_ctrl_20x32.sv
`default_nettype none
// ============================================================================
// Module  : tb_nv_ram_fifo_rd_ctrl_20x32
// Brief   : Scoreboard bench with a behavioural RAM for the FIFO read controller.
// Revision: 1.0
// ============================================================================
module tb_nv_ram_fifo_rd_ctrl_20x32;
    localparam int DEPTH = 20;
    localparam int WIDTH = 32;
    localparam int AW    = 5;
`ifdef NV_RAM_FIFO_RD_CTRL_BYPASS_EN
    localparam int LAT = 2;
`else
    localparam int LAT = 3;
`endif

    logic             clk = 1'b0;
    logic             rstn;
    logic             wr_pvld, wr_prdy, rd_pvld, rd_prdy;
    logic [WIDTH-1:0] wr_pd, rd_pd;
    logic             ram_we, ram_re, ram_ore, ram_byp_sel;
    logic [AW-1:0]    ram_wa, ram_ra;
    logic [WIDTH-1:0] ram_di, ram_dout, ram_dbyp;
    logic [31:0]      ram_pwrbus_pd;

    always #5 clk = ~clk;

    nv_ram_fifo_rd_ctrl_20x32 u_dut (
        .nvdla_core_clk  (clk),
        .nvdla_core_rstn (rstn),
        .wr_pvld         (wr_pvld),
        .wr_prdy         (wr_prdy),
        .wr_pd           (wr_pd),
        .rd_pvld         (rd_pvld),
        .rd_prdy         (rd_prdy),
        .rd_pd           (rd_pd),
        .ram_we          (ram_we),
        .ram_wa          (ram_wa),
        .ram_di          (ram_di),
        .ram_re          (ram_re),
        .ram_ra          (ram_ra),
        .ram_ore         (ram_ore),
        .ram_dout        (ram_dout),
        .ram_byp_sel     (ram_byp_sel),
        .ram_dbyp        (ram_dbyp),
        .ram_pwrbus_pd   (ram_pwrbus_pd)
    );

    // RAM model: data captured at read issue, moved to the output register on ore.
    logic [WIDTH-1:0] mem [32];
    logic [WIDTH-1:0] ram_lat;
    always @(posedge clk) begin
        if (ram_we)  mem[ram_wa] <= ram_di;
        if (ram_re)  ram_lat <= mem[ram_ra];
        if (ram_ore) ram_dout <= ram_byp_sel ? ram_dbyp : ram_lat;
    end

    int               n_chk = 0;
    int               n_pass = 0;
    logic [WIDTH-1:0] sb [$];
    int               cyc_no = 0;
    int               first_rd = -1;
    int               exp_wa = 0;
    int               exp_ra = 0;
    bit               wr_fire_q, rd_fire_q;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: observed 0x%0h, expected 0x%0h", tag, obs, exp);
    endtask

    // One clock cycle: inputs were set at the falling edge, sample shortly after.
    task automatic cyc();
        logic [WIDTH-1:0] exp_d;
        #1;
        wr_fire_q = wr_pvld && wr_prdy;
        rd_fire_q = rd_pvld && rd_prdy;
        if (ram_we) begin
            check("we_needs_push", 32'(wr_fire_q), 32'd1);
            check("ram_wa", 32'(ram_wa), 32'(exp_wa));
            check("ram_di", ram_di, wr_pd);
            exp_wa = (exp_wa == DEPTH - 1) ? 0 : exp_wa + 1;
        end
        if (ram_re) begin
            check("ram_ra", 32'(ram_ra), 32'(exp_ra));
            exp_ra = (exp_ra == DEPTH - 1) ? 0 : exp_ra + 1;
        end
        if (rd_fire_q) begin
            if (first_rd < 0) first_rd = cyc_no;
            if (sb.size() == 0) check("rd_unexpected", 32'd1, 32'd0);
            else begin
                exp_d = sb.pop_front();
                check("rd_pd", rd_pd, exp_d);
            end
        end
        if (wr_fire_q) sb.push_back(wr_pd);
        @(posedge clk);
        @(negedge clk);
        cyc_no++;
    endtask

    task automatic drain(input int max_cyc);
        rd_prdy = 1'b1;
        wr_pvld = 1'b0;
        for (int i = 0; i < max_cyc && sb.size() > 0; i++) cyc();
        repeat (4) cyc();
    endtask

    int t0, n_acc, k, c2, c40;

    initial begin
        rstn = 1'b0; wr_pvld = 1'b0; wr_pd = '0; rd_prdy = 1'b0;
        repeat (2) @(negedge clk);
        #1;
        check("rst_wr_prdy", 32'(wr_prdy), 32'd1);
        check("rst_rd_pvld", 32'(rd_pvld), 32'd0);
        check("rst_ram_we", 32'(ram_we), 32'd0);
        check("rst_ram_re", 32'(ram_re), 32'd0);
        check("rst_ram_ore", 32'(ram_ore), 32'd0);
        check("rst_byp_sel", 32'(ram_byp_sel), 32'd0);
        check("rst_pwrbus", ram_pwrbus_pd, 32'd0);
        @(negedge clk);
        rstn = 1'b1;
        cyc(); cyc();

        // Single word into an idle block
        rd_prdy = 1'b1; wr_pvld = 1'b1; wr_pd = 32'hA5A5_0001;
        first_rd = -1; t0 = cyc_no;
        cyc();
        wr_pvld = 1'b0;
        repeat (8) cyc();
        check("lat_idle", 32'(first_rd - t0), 32'(LAT));
        check("lat_sb_empty", 32'(sb.size()), 32'd0);

        // Fill with the consumer stalled
        rd_prdy = 1'b0; n_acc = 0;
        for (int i = 0; i < 40; i++) begin
            wr_pvld = 1'b1; wr_pd = 32'(n_acc);
            cyc();
            if (wr_fire_q) n_acc++;
        end
        wr_pvld = 1'b0;
        check("fill_accepted", 32'(n_acc), 32'(DEPTH + 3));
        check("fill_wr_prdy", 32'(wr_prdy), 32'd0);
        drain(100);
        check("fill_drained", 32'(sb.size()), 32'd0);

        // Simultaneous push and issue with 7 entries held in the RAM
        rd_prdy = 1'b0;
        for (int i = 0; i < 10; i++) begin
            wr_pvld = 1'b1; wr_pd = 32'h0700_0000 + 32'(i);
            cyc();
        end
        wr_pvld = 1'b0;
        repeat (3) cyc();
        check("cnt7_before", 32'(u_dut.r_cnt), 32'd7);
        rd_prdy = 1'b1;
        cyc();
        rd_prdy = 1'b0; wr_pvld = 1'b1; wr_pd = 32'h0700_00FF;
        #1;
        check("cnt7_we", 32'(ram_we), 32'd1);
        check("cnt7_re", 32'(ram_re), 32'd1);
        cyc();
        wr_pvld = 1'b0;
        check("cnt7_after", 32'(u_dut.r_cnt), 32'd7);
        drain(100);
        check("cnt7_drained", 32'(sb.size()), 32'd0);

        // Streaming with both sides ready
        rd_prdy = 1'b1; n_acc = 0; k = 0; c2 = -1; c40 = -1;
        for (int i = 0; i < 90 && k < 40; i++) begin
            wr_pvld = (n_acc < 40); wr_pd = 32'hB000_0000 + 32'(n_acc);
            cyc();
            if (wr_fire_q) n_acc++;
            if (rd_fire_q) begin
                k++;
                if (k == 2)  c2  = cyc_no - 1;
                if (k == 40) c40 = cyc_no - 1;
            end
        end
        wr_pvld = 1'b0;
        check("stream_count", 32'(k), 32'd40);
        check("stream_rate", 32'(c40 - c2), 32'd38);

        // Random consumer backpressure
        n_acc = 0; k = 0;
        for (int i = 0; i < 2000 && (n_acc < 100 || sb.size() > 0); i++) begin
            wr_pvld = (n_acc < 100); wr_pd = 32'h1000_0000 + 32'(n_acc);
            rd_prdy = 1'($urandom_range(0, 1));
            cyc();
            if (wr_fire_q) n_acc++;
            if (rd_fire_q) k++;
        end
        wr_pvld = 1'b0; rd_prdy = 1'b1;
        repeat (5) cyc();
        check("rand_pushed", 32'(n_acc), 32'd100);
        check("rand_read", 32'(k), 32'd100);
        check("rand_idle_pvld", 32'(rd_pvld), 32'd0);

        // Reset with data in flight
        rd_prdy = 1'b0;
        for (int i = 0; i < 5; i++) begin
            wr_pvld = 1'b1; wr_pd = 32'hDEAD_0000 + 32'(i);
            cyc();
        end
        wr_pvld = 1'b0;
        rstn = 1'b0;
        #1;
        check("midrst_rd_pvld", 32'(rd_pvld), 32'd0);
        check("midrst_wr_prdy", 32'(wr_prdy), 32'd1);
        check("midrst_cnt", 32'(u_dut.r_cnt), 32'd0);
        sb.delete(); exp_wa = 0; exp_ra = 0;
        @(negedge clk);
        rstn = 1'b1;
        cyc();
        rd_prdy = 1'b1; wr_pvld = 1'b1; wr_pd = 32'h0000_1234;
        first_rd = -1; t0 = cyc_no;
        cyc();
        wr_pvld = 1'b0;
        repeat (8) cyc();
        check("postrst_lat", 32'(first_rd - t0), 32'(LAT));
        check("postrst_sb_empty", 32'(sb.size()), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, checks %0d/%0d", n_pass, n_chk);
        $fatal(1);
    end
endmodule
`default_nettype wire
